// File: rtl/afifo_pkg.sv
// Shared async-FIFO helpers: default sizing and Gray/binary conversion.
package afifo_pkg;

    localparam int ADDRSIZE_DEF  = 4;
    localparam int DATASIZE_DEF  = 32;
    localparam int AEMPTY_TH_DEF = 2;

    // Pointers are at most 32 bits wide. Callers zero-extend their pointer
    // into these functions and cast the result back down. Leading zeros do
    // not disturb either conversion.
    function automatic logic [31:0] bin2gray(input logic [31:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [31:0] gray2bin(input logic [31:0] g);
        logic [31:0] b;
        b[31] = g[31];
        for (int i = 30; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/afifo_rptr_empty.sv
// Read-pointer / empty / level tracker for the rclk side of the async FIFO.
module afifo_rptr_empty
    import afifo_pkg::*;
#(
    parameter int ADDRSIZE  = ADDRSIZE_DEF,
    parameter int AEMPTY_TH = AEMPTY_TH_DEF
) (
    input  logic                rclk,
    input  logic                rrst,
    input  logic                rinc,
    input  logic [ADDRSIZE:0]   wptr_rclk,
    output logic [ADDRSIZE:0]   rptr,
    output logic [ADDRSIZE-1:0] raddr,
    output logic                rempty,
    output logic                raempty,
    output logic [ADDRSIZE:0]   rlevel
);

    localparam int PW = ADDRSIZE + 1;
    localparam logic [PW-1:0] TH   = PW'(AEMPTY_TH);
    localparam logic [PW-1:0] FULL = {1'b1, {ADDRSIZE{1'b0}}};

    logic [PW-1:0] rbin;
    logic [PW-1:0] rbinnext;
    logic [PW-1:0] rgraynext;
    logic [PW-1:0] wbin_s;
    logic [PW-1:0] lvlnext;

    // Next pointer and the level it leaves behind. The level is computed
    // modulo 2^PW, so the full case shows up as MSB set and the low bits
    // cleared.
    always_comb begin
        rbinnext  = rbin + PW'(rinc);
        rgraynext = PW'(bin2gray(32'(rbinnext)));
        wbin_s    = PW'(gray2bin(32'(wptr_rclk)));
        lvlnext   = wbin_s - rbinnext;
    end

    assign raddr = rbin[ADDRSIZE-1:0];

    // Pointer, empty and level registers. Empty is pessimistic because it
    // compares against a write pointer that is already two flops stale.
    always_ff @(posedge rclk or posedge rrst) begin
        if (rrst) begin
            rbin    <= '0;
            rptr    <= '0;
            rempty  <= 1'b1;
            raempty <= 1'b1;
            rlevel  <= '0;
        end else begin
            rbin    <= rbinnext;
            rptr    <= rgraynext;
            rempty  <= (rgraynext == wptr_rclk);
            raempty <= (lvlnext <= TH);
            rlevel  <= lvlnext;
        end
    end

    a_gray_step: assert property (@(posedge rclk) disable iff (rrst)
        $countones(rptr ^ $past(rptr)) <= 1);
    a_no_pop_empty: assert property (@(posedge rclk) disable iff (rrst)
        rinc |-> !rempty);
    a_level_range: assert property (@(posedge rclk) disable iff (rrst)
        rlevel <= FULL);

endmodule

// File: rtl/afifo_rd_ctrl.sv
// Read-domain controller: pointer/empty tracking plus an FWFT valid/ready stage.
module afifo_rd_ctrl
    import afifo_pkg::*;
#(
    parameter int ADDRSIZE  = ADDRSIZE_DEF,
    parameter int DATASIZE  = DATASIZE_DEF,
    parameter int AEMPTY_TH = AEMPTY_TH_DEF
) (
    input  logic                rclk,
    input  logic                rrst,
    input  logic [ADDRSIZE:0]   wptr_rclk,
    output logic [ADDRSIZE:0]   rptr,
    output logic [ADDRSIZE-1:0] raddr,
    input  logic [DATASIZE-1:0] mem_rdata,
    output logic                rempty,
    output logic                raempty,
    output logic [ADDRSIZE:0]   rlevel,
    output logic                rvalid,
    output logic [DATASIZE-1:0] rdata,
    input  logic                rready
);

    logic rpop;

    // Refill whenever memory has a word and the stage is free or is being
    // drained this cycle. This gives back-to-back words with no bubble.
    assign rpop = ~rempty & (~rvalid | rready);

    afifo_rptr_empty #(
        .ADDRSIZE  (ADDRSIZE),
        .AEMPTY_TH (AEMPTY_TH)
    ) u_rptr_empty (
        .rclk      (rclk),
        .rrst      (rrst),
        .rinc      (rpop),
        .wptr_rclk (wptr_rclk),
        .rptr      (rptr),
        .raddr     (raddr),
        .rempty    (rempty),
        .raempty   (raempty),
        .rlevel    (rlevel)
    );

    // Output stage. Capture on pop and release on consume. The stage holds
    // while the consumer stalls.
    always_ff @(posedge rclk or posedge rrst) begin
        if (rrst) begin
            rvalid <= 1'b0;
            rdata  <= '0;
        end else if (rpop) begin
            rvalid <= 1'b1;
            rdata  <= mem_rdata;
        end else if (rvalid && rready) begin
            rvalid <= 1'b0;
        end
    end

    a_hold: assert property (@(posedge rclk) disable iff (rrst)
        rvalid && !rready |=> rvalid && $stable(rdata));

endmodule
